// File: rtl/key_pkg.sv
// Shared encodings for the key event controller: event types, per-key FSM
// states and the tick counter width.
package key_pkg;

   localparam int CNT_W = 27;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic [1:0] {
      EVT_SHORT  = 2'd0,
      EVT_LONG   = 2'd1,
      EVT_REPEAT = 2'd2,
      EVT_RSVD   = 2'd3
   } evt_type_e;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_PRESS = 2'd1;
   localparam logic [1:0] ST_HELD  = 2'd2;

endpackage

// File: rtl/key_press_fsm.sv
// Per-key press classifier: turns one debounced active-low key into
// single-cycle SHORT / LONG / REPEAT event strobes.
module key_press_fsm
   import key_pkg::*;
#(
   parameter logic [CNT_W-1:0] LONG_TICKS   = 27'd125_000_000,
   parameter logic [CNT_W-1:0] REPEAT_TICKS = 27'd25_000_000
) (
   input  logic      sys_clk,
   input  logic      sys_rst,
   input  logic      key_i,
   output logic      evt_o,
   output evt_type_e evt_type_o
);

   localparam logic [CNT_W-1:0] LONG_LAST   = LONG_TICKS - CNT_ONE;
   localparam logic [CNT_W-1:0] REPEAT_LAST = REPEAT_TICKS - CNT_ONE;

   logic             k_q;
   logic             arm_q;
   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             press_w, rel_w;

   // A key held through reset stays disarmed until it has been seen released.
   assign press_w = k_q & ~key_i & arm_q;
   assign rel_w   = ~k_q & key_i;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_d    = state_q;
      cnt_d      = cnt_q;
      evt_o      = 1'b0;
      evt_type_o = EVT_SHORT;
      case (state_q)
         ST_PRESS: begin
            if (rel_w) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               evt_o   = 1'b1;
            end else if (cnt_q == LONG_LAST) begin
               state_d    = ST_HELD;
               cnt_d      = '0;
               evt_o      = 1'b1;
               evt_type_o = EVT_LONG;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_HELD: begin
            if (rel_w) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == REPEAT_LAST) begin
               cnt_d      = '0;
               evt_o      = 1'b1;
               evt_type_o = EVT_REPEAT;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            cnt_d = '0;
            if (press_w) state_d = ST_PRESS;
         end
      endcase
   end

   always_ff @(posedge sys_clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (sys_rst) begin
         k_q     <= 1'b1;
         arm_q   <= key_i;
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         k_q     <= key_i;
         arm_q   <= arm_q | key_i;
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/key_event_ctrl.sv
// Key event controller: per-key classifiers feed one-deep pending slots,
// a round-robin arbiter and a valid/ready output register.
module key_event_ctrl
   import key_pkg::*;
#(
   parameter int               N_KEYS       = 4,
   parameter logic [CNT_W-1:0] LONG_TICKS   = 27'd125_000_000,
   parameter logic [CNT_W-1:0] REPEAT_TICKS = 27'd25_000_000
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic [N_KEYS-1:0] key_filter,
   output logic              evt_valid,
   input  logic              evt_ready,
   output logic [1:0]        evt_key,
   output logic [1:0]        evt_type,
   output logic              evt_ovf
);

   logic [N_KEYS-1:0]       raise_w;
   evt_type_e               raise_type_w [N_KEYS];
   logic [N_KEYS-1:0]       pend_q, pend_d;
   logic [N_KEYS-1:0][1:0]  pend_type_q, pend_type_d;
   logic [N_KEYS-1:0]       ovf_vec;
   logic [1:0]              ptr_q;
   logic [1:0]              cand;
   logic [1:0]              grant_idx;
   logic                    grant_vld;
   logic                    load;
   logic                    evt_valid_q;
   logic [1:0]              evt_key_q;
   logic [1:0]              evt_type_q;
   logic                    evt_ovf_q;

   for (genvar g = 0; g < N_KEYS; g++) begin : g_key
      key_press_fsm #(
         .LONG_TICKS   (LONG_TICKS),
         .REPEAT_TICKS (REPEAT_TICKS)
      ) u_fsm (
         .sys_clk    (sys_clk),
         .sys_rst    (sys_rst),
         .key_i      (key_filter[g]),
         .evt_o      (raise_w[g]),
         .evt_type_o (raise_type_w[g])
      );
   end

   // Search starts one past the last grant; the 2-bit add wraps modulo 4.
   always_comb begin
      cand      = '0;
      grant_vld = 1'b0;
      grant_idx = ptr_q;
      for (int k = 1; k <= N_KEYS; k++) begin
         cand = ptr_q + 2'(k);
         if (!grant_vld && pend_q[cand]) begin
            grant_vld = 1'b1;
            grant_idx = cand;
         end
      end
   end

   assign load = (!evt_valid_q || evt_ready) && grant_vld;

   // A fresh event beats the clear of its own slot being loaded this cycle.
   always_comb begin
      pend_d      = pend_q;
      pend_type_d = pend_type_q;
      ovf_vec     = '0;
      for (int i = 0; i < N_KEYS; i++) begin
         if (load && grant_idx == 2'(i)) pend_d[i] = 1'b0;
         if (raise_w[i]) begin
            ovf_vec[i]     = pend_q[i] && !(load && grant_idx == 2'(i));
            pend_d[i]      = 1'b1;
            pend_type_d[i] = raise_type_w[i];
         end
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         // NOTE: the pending slots are reset too, since a stale type would otherwise leak out after reset.
         pend_q      <= '0;
         pend_type_q <= '0;
         ptr_q       <= 2'(N_KEYS - 1);
         evt_valid_q <= 1'b0;
         evt_key_q   <= '0;
         evt_type_q  <= '0;
         evt_ovf_q   <= 1'b0;
      end else begin
         pend_q      <= pend_d;
         pend_type_q <= pend_type_d;
         evt_ovf_q   <= |ovf_vec;
         if (load) begin
            evt_valid_q <= 1'b1;
            evt_key_q   <= grant_idx;
            evt_type_q  <= pend_type_q[grant_idx];
            ptr_q       <= grant_idx;
         end else if (evt_ready) begin
            evt_valid_q <= 1'b0;
         end
      end
   end

   assign evt_valid = evt_valid_q;
   assign evt_key   = evt_key_q;
   assign evt_type  = evt_type_q;
   assign evt_ovf   = evt_ovf_q;

endmodule

// File: tb/tb_key_event_ctrl.sv
// Directed bench for key_event_ctrl with short thresholds (LONG 10, REPEAT 4).
module tb_key_event_ctrl;
   import key_pkg::*;

   typedef struct packed {
      logic [1:0]  key;
      logic [1:0]  typ;
      logic [15:0] cyc;
   } ev_t;

   logic       sys_clk = 1'b0;
   logic       sys_rst;
   logic [3:0] key_filter;
   logic       evt_valid;
   logic       evt_ready;
   logic [1:0] evt_key;
   logic [1:0] evt_type;
   logic       evt_ovf;

   ev_t ev_q[$];
   int  ovf_cyc_q[$];
   int  cyc;
   int  checks = 0;
   int  errors = 0;

   key_event_ctrl #(
      .N_KEYS       (4),
      .LONG_TICKS   (27'd10),
      .REPEAT_TICKS (27'd4)
   ) dut (
      .sys_clk    (sys_clk),
      .sys_rst    (sys_rst),
      .key_filter (key_filter),
      .evt_valid  (evt_valid),
      .evt_ready  (evt_ready),
      .evt_key    (evt_key),
      .evt_type   (evt_type),
      .evt_ovf    (evt_ovf)
   );

   always #5 sys_clk = ~sys_clk;

   // Log accepted events and overflow pulses for the current cycle, then advance one edge.
   task automatic step();
      if (evt_valid && evt_ready) ev_q.push_back('{evt_key, evt_type, 16'(cyc)});
      if (evt_ovf) ovf_cyc_q.push_back(cyc);
      @(posedge sys_clk);
      #1;
      cyc++;
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic do_reset();
      sys_rst    = 1'b1;
      key_filter = 4'hF;
      evt_ready  = 1'b1;
      step();
      step();
      sys_rst = 1'b0;
      cyc     = 0;
      ev_q.delete();
      ovf_cyc_q.delete();
   endtask

   task automatic test_reset();
      sys_rst    = 1'b1;
      key_filter = 4'hF;
      evt_ready  = 1'b1;
      @(posedge sys_clk);
      #1;
      checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", evt_valid); end
      checks++; if (evt_key !== 2'd0) begin errors++; $display("FAIL reset_key: got %b expected 0", evt_key); end
      checks++; if (evt_type !== 2'd0) begin errors++; $display("FAIL reset_type: got %b expected 0", evt_type); end
      checks++; if (evt_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", evt_ovf); end
      do_reset();
      run(12);
      checks++; if (ev_q.size() != 0) begin errors++; $display("FAIL reset_idle: got %0d events expected 0", ev_q.size()); end
   endtask

   task automatic test_short();
      ev_t exp_q[$];
      do_reset();
      key_filter[0] = 1'b0;
      run(5);
      key_filter[0] = 1'b1;
      run(1);
      checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL short_early: valid=%b expected 0 at cycle %0d", evt_valid, cyc); end
      run(1);
      checks++; if (evt_valid !== 1'b1) begin errors++; $display("FAIL short_valid: valid=%b expected 1 at cycle %0d", evt_valid, cyc); end
      checks++; if (evt_key !== 2'd0 || evt_type !== 2'(EVT_SHORT)) begin errors++; $display("FAIL short_out: key=%0d type=%0d expected key=0 type=0", evt_key, evt_type); end
      run(10);
      exp_q.push_back('{2'd0, EVT_SHORT, 16'd7});
      checks++;
      if (ev_q.size() != exp_q.size()) begin
         errors++; $display("FAIL short_count: got %0d events expected %0d", ev_q.size(), exp_q.size());
      end else foreach (exp_q[i]) begin
         checks++; if (ev_q[i] !== exp_q[i]) begin errors++; $display("FAIL short_ev%0d: got key=%0d type=%0d cyc=%0d expected key=%0d type=%0d cyc=%0d", i, ev_q[i].key, ev_q[i].typ, ev_q[i].cyc, exp_q[i].key, exp_q[i].typ, exp_q[i].cyc); end
      end
   endtask

   task automatic test_long_repeat();
      ev_t exp_q[$];
      do_reset();
      key_filter[2] = 1'b0;
      run(20);
      key_filter[2] = 1'b1;
      run(20);
      exp_q.push_back('{2'd2, EVT_LONG,   16'd12});
      exp_q.push_back('{2'd2, EVT_REPEAT, 16'd16});
      exp_q.push_back('{2'd2, EVT_REPEAT, 16'd20});
      checks++;
      if (ev_q.size() != exp_q.size()) begin
         errors++; $display("FAIL long_count: got %0d events expected %0d", ev_q.size(), exp_q.size());
      end else foreach (exp_q[i]) begin
         checks++; if (ev_q[i] !== exp_q[i]) begin errors++; $display("FAIL long_ev%0d: got key=%0d type=%0d cyc=%0d expected key=%0d type=%0d cyc=%0d", i, ev_q[i].key, ev_q[i].typ, ev_q[i].cyc, exp_q[i].key, exp_q[i].typ, exp_q[i].cyc); end
      end
      checks++; if (ovf_cyc_q.size() != 0) begin errors++; $display("FAIL long_ovf: got %0d pulses expected 0", ovf_cyc_q.size()); end
   endtask

   task automatic test_release_wins();
      ev_t exp_q[$];
      do_reset();
      key_filter[1] = 1'b0;
      run(10);
      key_filter[1] = 1'b1;
      run(15);
      exp_q.push_back('{2'd1, EVT_SHORT, 16'd12});
      checks++;
      if (ev_q.size() != exp_q.size()) begin
         errors++; $display("FAIL race_count: got %0d events expected %0d", ev_q.size(), exp_q.size());
      end else foreach (exp_q[i]) begin
         checks++; if (ev_q[i] !== exp_q[i]) begin errors++; $display("FAIL race_ev%0d: got key=%0d type=%0d cyc=%0d expected key=%0d type=%0d cyc=%0d", i, ev_q[i].key, ev_q[i].typ, ev_q[i].cyc, exp_q[i].key, exp_q[i].typ, exp_q[i].cyc); end
      end
   endtask

   task automatic test_back_to_back();
      ev_t exp_q[$];
      do_reset();
      evt_ready  = 1'b0;
      key_filter = 4'b0110;
      run(3);
      key_filter = 4'hF;
      run(2);
      for (int n = 0; n < 5; n++) begin
         checks++; if (evt_valid !== 1'b1 || evt_key !== 2'd0 || evt_type !== 2'(EVT_SHORT)) begin errors++; $display("FAIL b2b_hold: cycle %0d valid=%b key=%0d type=%0d expected 1/0/0", cyc, evt_valid, evt_key, evt_type); end
         step();
      end
      evt_ready = 1'b1;
      step();
      checks++; if (evt_valid !== 1'b1 || evt_key !== 2'd3 || evt_type !== 2'(EVT_SHORT)) begin errors++; $display("FAIL b2b_next: valid=%b key=%0d type=%0d expected 1/3/0", evt_valid, evt_key, evt_type); end
      step();
      checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: valid=%b expected 0", evt_valid); end
      exp_q.push_back('{2'd0, EVT_SHORT, 16'd10});
      exp_q.push_back('{2'd3, EVT_SHORT, 16'd11});
      checks++;
      if (ev_q.size() != exp_q.size()) begin
         errors++; $display("FAIL b2b_count: got %0d events expected %0d", ev_q.size(), exp_q.size());
      end else foreach (exp_q[i]) begin
         checks++; if (ev_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_ev%0d: got key=%0d type=%0d cyc=%0d expected key=%0d type=%0d cyc=%0d", i, ev_q[i].key, ev_q[i].typ, ev_q[i].cyc, exp_q[i].key, exp_q[i].typ, exp_q[i].cyc); end
      end
   endtask

   task automatic test_overflow();
      ev_t exp_q[$];
      do_reset();
      evt_ready     = 1'b0;
      key_filter[1] = 1'b0;
      run(20);
      key_filter[1] = 1'b1;
      run(5);
      checks++; if (evt_valid !== 1'b1 || evt_key !== 2'd1 || evt_type !== 2'(EVT_LONG)) begin errors++; $display("FAIL ovf_stall: valid=%b key=%0d type=%0d expected 1/1/1", evt_valid, evt_key, evt_type); end
      checks++;
      if (ovf_cyc_q.size() != 1) begin
         errors++; $display("FAIL ovf_count: got %0d pulses expected 1", ovf_cyc_q.size());
      end else begin
         checks++; if (ovf_cyc_q[0] != 19) begin errors++; $display("FAIL ovf_cycle: got %0d expected 19", ovf_cyc_q[0]); end
      end
      evt_ready = 1'b1;
      run(10);
      exp_q.push_back('{2'd1, EVT_LONG,   16'd25});
      exp_q.push_back('{2'd1, EVT_REPEAT, 16'd26});
      checks++;
      if (ev_q.size() != exp_q.size()) begin
         errors++; $display("FAIL ovf_evcount: got %0d events expected %0d", ev_q.size(), exp_q.size());
      end else foreach (exp_q[i]) begin
         checks++; if (ev_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_ev%0d: got key=%0d type=%0d cyc=%0d expected key=%0d type=%0d cyc=%0d", i, ev_q[i].key, ev_q[i].typ, ev_q[i].cyc, exp_q[i].key, exp_q[i].typ, exp_q[i].cyc); end
      end
   endtask

   task automatic test_reset_mid_hold();
      ev_t exp_q[$];
      do_reset();
      evt_ready  = 1'b0;
      key_filter = 4'b1001;
      run(3);
      key_filter = 4'hF;
      run(1);
      key_filter[0] = 1'b0;
      run(7);
      checks++; if (evt_valid !== 1'b1 || evt_key !== 2'd1) begin errors++; $display("FAIL rst_pre: valid=%b key=%0d expected 1/1", evt_valid, evt_key); end
      sys_rst = 1'b1;
      step();
      sys_rst = 1'b0;
      checks++; if (evt_valid !== 1'b0 || evt_key !== 2'd0 || evt_type !== 2'd0) begin errors++; $display("FAIL rst_clear: valid=%b key=%0d type=%0d expected 0/0/0", evt_valid, evt_key, evt_type); end
      evt_ready = 1'b1;
      ev_q.delete();
      run(28);
      checks++; if (ev_q.size() != 0) begin errors++; $display("FAIL rst_quiet: got %0d events expected 0", ev_q.size()); end
      key_filter[0] = 1'b1;
      run(5);
      key_filter[0] = 1'b0;
      run(3);
      key_filter[0] = 1'b1;
      run(10);
      exp_q.push_back('{2'd0, EVT_SHORT, 16'd50});
      checks++;
      if (ev_q.size() != exp_q.size()) begin
         errors++; $display("FAIL rst_count: got %0d events expected %0d", ev_q.size(), exp_q.size());
      end else foreach (exp_q[i]) begin
         checks++; if (ev_q[i] !== exp_q[i]) begin errors++; $display("FAIL rst_ev%0d: got key=%0d type=%0d cyc=%0d expected key=%0d type=%0d cyc=%0d", i, ev_q[i].key, ev_q[i].typ, ev_q[i].cyc, exp_q[i].key, exp_q[i].typ, exp_q[i].cyc); end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      cyc = 0;
      test_reset();
      test_short();
      test_long_repeat();
      test_release_wins();
      test_back_to_back();
      test_overflow();
      test_reset_mid_hold();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/key_event_ctrl.md
KEY_EVENT_CTRL -- requirements
Module: key_event_ctrl

Interface
REQ-001 Parameter N_KEYS, default 4: number of debounced key inputs; fixed at 4 in this revision.
REQ-002 Parameter LONG_TICKS, default 27'd125_000_000: hold time that qualifies a long press (0.5 s at 250 MHz).
REQ-003 Parameter REPEAT_TICKS, default 27'd25_000_000: auto-repeat period after a long press (100 ms at 250 MHz).
REQ-004 sys_clk  in  1  sole clock; all logic rising-edge.
REQ-005 sys_rst  in  1  reset, synchronous, active-high.
REQ-006 key_filter  in  4  debounced keys from key_debounce instances; active-low (1 = released).
REQ-007 evt_valid  out  1  event available.
REQ-008 evt_ready  in  1  consumer accepts the event on a cycle where evt_valid && evt_ready.
REQ-009 evt_key  out  2  index of the key that produced the event.
REQ-010 evt_type  out  2  event type: 0 = SHORT, 1 = LONG, 2 = REPEAT, 3 = reserved (never emitted).
REQ-011 evt_ovf  out  1  one-cycle pulse when a pending event is overwritten before it is consumed.

Function
REQ-012 Each key SHALL register key_filter once (k_d); press = k_d & ~key_filter[i], release = ~k_d & key_filter[i].
REQ-013 Each key SHALL run its own FSM with states IDLE, PRESS, HELD, and a 27-bit tick counter.
REQ-014 IDLE -> PRESS on press; counter cleared to 0.
REQ-015 PRESS: counter increments every cycle. Release -> IDLE and raise SHORT. Counter reaching LONG_TICKS-1 -> HELD, raise LONG, counter cleared.
REQ-016 HELD: counter increments. Counter reaching REPEAT_TICKS-1 -> raise REPEAT, counter cleared. Release -> IDLE with no event.
REQ-017 If release and threshold occur in the same cycle, release SHALL win: SHORT in PRESS, no event in HELD.
REQ-018 A raised event SHALL set a one-deep pending register per key, holding the type.
REQ-019 If a key's pending register is already set when a new event is raised, the new type SHALL overwrite the old one and evt_ovf SHALL pulse.
REQ-020 The output register SHALL load when (!evt_valid || evt_ready) and any pending bit is set.
REQ-021 On that load the winner's pending bit SHALL clear; evt_valid, evt_key and evt_type SHALL update on the next edge.
REQ-022 Winner selection SHALL be round-robin: the search starts at (last granted key + 1) mod 4, with the pointer reset to 3 so key 0 has first priority.
REQ-023 If an event is raised and that key's pending bit is loaded in the same cycle, the new event SHALL remain pending; set has priority over clear, and evt_ovf does not pulse.
REQ-024 evt_valid SHALL stay high and evt_key/evt_type SHALL stay stable until accepted; back-to-back accepts SHALL sustain one event per cycle.
REQ-025 Latency from key_filter edge to evt_valid SHALL be 2 cycles with an empty output register and no contention.
REQ-026 Counters SHALL never wrap; each is cleared on every threshold and in IDLE.

Reset
REQ-027 sys_rst SHALL force all FSMs to IDLE, counters to 0, k_d to 1, all pending bits to 0, and the round-robin pointer to 3.
REQ-028 During reset, outputs SHALL be: evt_valid = 0, evt_key = 0, evt_type = 0, evt_ovf = 0.
REQ-029 Reset asserted mid-hold or with a pending event SHALL discard all state; a key still held after reset SHALL NOT generate an event until it is released and pressed again.

Structure
REQ-030 The event type encodings and FSM state encodings SHALL live in the shared package key_pkg.
REQ-031 The per-key FSM and counter SHALL be the sub-module key_press_fsm, instantiated N_KEYS times.
REQ-032 Pending registers, arbiter and output register SHALL live in the key_event_ctrl top level.

Verification (bench uses LONG_TICKS = 10, REPEAT_TICKS = 4, evt_ready = 1 unless stated)
REQ-033 Key0 low for 5 cycles then high -> exactly one event {key 0, SHORT}, evt_valid 2 cycles after the release edge.
REQ-034 Key2 low for 20 cycles -> {2, LONG} at hold cycle 10, then {2, REPEAT} at hold cycles 14 and 18, and nothing on release.
REQ-035 Keys 0 and 3 released together after a short press, evt_ready = 0 for 5 cycles -> {0, SHORT} held stable, then {3, SHORT} on the next cycle after acceptance.
REQ-036 Key1 held with evt_ready = 0 throughout LONG and two REPEATs -> evt_ovf pulses once; after evt_ready = 1, the outputs are the first LONG and then the latest REPEAT.
REQ-037 Key1 release coinciding with hold cycle 10 -> a single SHORT and no LONG.
REQ-038 sys_rst pulsed at hold cycle 7 of key0 with a pending event -> evt_valid = 0 the next cycle, and no events until key0 is released and pressed again.
